alu_req_arbiter: RTL and testbench

//  Shares the single registered ALU (ctrl_valid in -> alu_valid out one cycle later) between NREQ requesters.

---
 rtl/alu_req_arbiter_pkg.sv | 25 ++
 rtl/alu_req_arbiter_rr.sv | 37 +++
 rtl/alu_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter.
// ALU op codes and the arbiter FSM state encoding.
package alu_req_arbiter_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [3:0] OP_SET = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_rr.sv
// Combinational round-robin picker.
// Lowest distance (mod NREQ) from the pointer wins.
module alu_req_arbiter_rr #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int w_best;
    int w_d;

    // Find the requester closest to the pointer, walking upward.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_best  = NREQ;
        w_d     = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_d = (j + NREQ - int'(i_ptr)) % NREQ;
            if (i_req[j] && (w_d < w_best)) begin
                w_best = w_d;
                o_idx  = IW'(j);
            end
        end
        if (w_best < NREQ) begin
            o_any          = 1'b1;
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between NREQ requesters.
// One op in flight; round-robin grant; timeout response.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*4-1:0]    req_ctrl,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ-1:0]      req_sign,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [DATA_W-1:0]    resp_result,
    output logic [3:0]           resp_flags,
    output logic                 resp_err,
    output logic                 alu_ctrl_valid,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_ctrl,
    output logic                 alu_sub,
    output logic                 alu_sign,
    input  logic                 alu_valid,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zf,
    input  logic                 alu_of,
    input  logic                 alu_cf,
    input  logic                 alu_branch,
    output logic                 busy
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_gidx;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_ctrl;
    logic              r_sub;
    logic              r_sign;
    logic              r_ctrl_valid;
    logic [NREQ-1:0]   r_resp_valid;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    logic              r_err;

    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic [NREQ-1:0]   w_gsel;
    logic [IW-1:0]     w_ptr_nxt;

    alu_req_arbiter_rr #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_gsel    = NREQ'(1) << r_gidx;
    assign w_ptr_nxt = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

    assign req_ready      = (r_state == ST_IDLE) ? w_grant : '0;
    assign busy           = (r_state != ST_IDLE);
    assign resp_valid     = r_resp_valid;
    assign resp_result    = r_result;
    assign resp_flags     = r_flags;
    assign resp_err       = r_err;
    assign alu_ctrl_valid = r_ctrl_valid;
    assign alu_a          = r_a;
    assign alu_b          = r_b;
    assign alu_ctrl       = r_ctrl;
    assign alu_sub        = r_sub;
    assign alu_sign       = r_sign;

    // Grant, launch, wait/timeout and response FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_ctrl       <= '0;
            r_sub        <= 1'b0;
            r_sign       <= 1'b0;
            r_ctrl_valid <= 1'b0;
            r_resp_valid <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_ctrl_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gidx       <= w_idx;
                        r_a          <= req_a[w_idx*DATA_W +: DATA_W];
                        r_b          <= req_b[w_idx*DATA_W +: DATA_W];
                        r_ctrl       <= req_ctrl[w_idx*4 +: 4];
                        r_sub        <= req_sub[w_idx];
                        r_sign       <= req_sign[w_idx];
                        r_ctrl_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_valid) begin
                        r_result     <= alu_result;
                        r_flags      <= {alu_branch, alu_cf, alu_of, alu_zf};
                        r_err        <= 1'b0;
                        r_resp_valid <= w_gsel;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == CW'(WAIT_MAX - 1)) begin
                        r_result     <= '0;
                        r_flags      <= '0;
                        r_err        <= 1'b1;
                        r_resp_valid <= w_gsel;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (|(resp_ready & r_resp_valid)) begin
                        r_resp_valid <= '0;
                        r_ptr        <= w_ptr_nxt;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed cases then random traffic.
// Scoreboard queue filled at accept, drained by the response monitor.
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int WMAX = 7;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    always #5 clock = ~clock;

    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic [NREQ*4-1:0]  req_ctrl = '0;
    logic [NREQ-1:0]    req_sub = '0;
    logic [NREQ-1:0]    req_sign = '0;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready = '0;
    logic [DW-1:0]      resp_result;
    logic [3:0]         resp_flags;
    logic               resp_err;
    logic               alu_ctrl_valid;
    logic [DW-1:0]      alu_a, alu_b;
    logic [3:0]         alu_ctrl;
    logic               alu_sub, alu_sign;
    logic               alu_valid;
    logic [DW-1:0]      alu_result;
    logic               alu_zf, alu_of, alu_cf, alu_branch;
    logic               busy;

    alu_req_arbiter #(.NREQ(NREQ), .DATA_W(DW), .WAIT_MAX(WMAX)) dut (
        .clock(clock), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .req_sub(req_sub), .req_sign(req_sign),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .resp_err(resp_err), .alu_ctrl_valid(alu_ctrl_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_sub(alu_sub), .alu_sign(alu_sign),
        .alu_valid(alu_valid), .alu_result(alu_result),
        .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf),
        .alu_branch(alu_branch), .busy(busy)
    );

    typedef struct {
        int          g;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   served[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nresp = 0;

    // model state (owned by the monitor)
    logic            m_busy = 1'b0;
    int              m_ptr = 0;
    int              m_g = 0;
    int              m_t = 0;
    int              m_due = 0;
    logic [31:0]     m_a, m_b;
    logic [3:0]      m_op;
    logic            m_sub, m_sign;
    logic [NREQ-1:0] acc_seen = '0;
    logic [NREQ-1:0] outstanding = '0;
    logic            cur_supp = 1'b0;
    logic            force_supp = 1'b0;
    logic            rand_supp = 1'b0;
    int              rr_mode = 0;
    logic [31:0]     last_res;
    logic [3:0]      last_fl;
    logic            last_err;

    logic [3:0] ops [12] = '{OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL,
                             OP_SRA, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_SET};

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    // reference ALU: returns {result, branch, CF, OF, ZF}
    function automatic logic [35:0] alu_ref(logic [3:0] op, logic [31:0] a,
                                            logic [31:0] b, logic sub, logic sign);
        logic [32:0] s, d;
        logic [31:0] r;
        logic cf, of, br, lt, eq;
        d  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        eq = (a == b);
        lt = sign ? ($signed(a) < $signed(b)) : (a < b);
        r = '0; cf = 1'b0; of = 1'b0; br = 1'b0;
        case (op)
            OP_ADD: begin
                s  = sub ? d : ({1'b0, a} + {1'b0, b});
                r  = s[31:0];
                cf = s[32];
                of = sub ? (a[31] != b[31] && r[31] != a[31])
                         : (a[31] == b[31] && r[31] != a[31]);
            end
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_SLL: r = a << b[4:0];
            OP_SRL: r = a >> b[4:0];
            OP_SRA: r = $unsigned($signed(a) >>> b[4:0]);
            OP_BEQ: begin r = d[31:0]; br = eq;  end
            OP_BNE: begin r = d[31:0]; br = !eq; end
            OP_BLT: begin r = d[31:0]; br = lt;  end
            OP_BGE: begin r = d[31:0]; br = !lt; end
            OP_SET: r = {31'b0, lt};
            default: r = '0;
        endcase
        return {r, br, cf, of, (r == 32'd0)};
    endfunction

    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // behavioural ALU: one-cycle registered, can be muted per op
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid  <= 1'b0;
            alu_result <= '0;
            {alu_branch, alu_cf, alu_of, alu_zf} <= '0;
        end else begin
            alu_valid <= alu_ctrl_valid && !cur_supp;
            {alu_result, alu_branch, alu_cf, alu_of, alu_zf} <=
                alu_ref(alu_ctrl, alu_a, alu_b, alu_sub, alu_sign);
        end
    end

    // monitor / scoreboard
    int              gi;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic            supp;
    exp_t            e;
    initial begin
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (!rst_n) begin
                chk("rst_ctl", {resp_valid, req_ready, alu_ctrl_valid, busy,
                                resp_err, resp_flags}, 64'd0);
                chk("rst_data", {resp_result, alu_a}, 64'd0);
                q.delete();
                m_busy = 1'b0; m_ptr = 0;
                outstanding = '0; acc_seen = '0;
            end else begin
                gi = m_busy ? -1 : pick(req_valid, m_ptr);
                exp_rdy = (gi >= 0) ? (NREQ'(1) << gi) : '0;
                chk("req_ready", 64'(req_ready), 64'(exp_rdy));
                chk("busy", 64'(busy), 64'(m_busy));
                chk("ctrl_valid", 64'(alu_ctrl_valid),
                    64'(m_busy && cyc == m_t + 1));
                if (m_busy && cyc == m_t + 1) begin
                    chk("launch_ops", {alu_a, alu_b}, {m_a, m_b});
                    chk("launch_ctl", {alu_ctrl, alu_sub, alu_sign},
                        {m_op, m_sub, m_sign});
                end
                exp_rv = (m_busy && cyc >= m_due) ? (NREQ'(1) << m_g) : '0;
                chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
                if (resp_valid != 0 && q.size() > 0)
                    chk("resp_data", {resp_err, resp_flags, resp_result},
                        {q[0].err, q[0].fl, q[0].res});
                if (m_busy && cyc >= m_due && resp_ready[m_g]) begin
                    last_res = resp_result;
                    last_fl  = resp_flags;
                    last_err = resp_err;
                    if (q.size() > 0) void'(q.pop_front());
                    m_busy = 1'b0;
                    m_ptr  = (m_g + 1) % NREQ;
                    outstanding[m_g] = 1'b0;
                    nresp++;
                end
                if (gi >= 0) begin
                    m_g    = gi;
                    m_a    = req_a[gi*DW +: DW];
                    m_b    = req_b[gi*DW +: DW];
                    m_op   = req_ctrl[gi*4 +: 4];
                    m_sub  = req_sub[gi];
                    m_sign = req_sign[gi];
                    supp   = force_supp || (rand_supp && $urandom_range(0, 7) == 0);
                    e.g    = gi;
                    if (supp) begin
                        e.res = '0; e.fl = '0; e.err = 1'b1;
                    end else begin
                        {e.res, e.fl} = alu_ref(m_op, m_a, m_b, m_sub, m_sign);
                        e.err = 1'b0;
                    end
                    q.push_back(e);
                    served.push_back(gi);
                    m_busy   = 1'b1;
                    m_t      = cyc;
                    m_due    = cyc + (supp ? 2 + WMAX : 3);
                    cur_supp = supp;
                    acc_seen[gi]    = 1'b1;
                    outstanding[gi] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        for (int i = 0; i < NREQ; i++)
            if (acc_seen[i]) begin
                req_valid[i] = 1'b0;
                acc_seen[i]  = 1'b0;
            end
        case (rr_mode)
            1:       resp_ready = '0;
            2:       resp_ready = NREQ'($urandom);
            default: resp_ready = '1;
        endcase
    endtask

    task automatic post(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic s, logic g);
        req_valid[i]      = 1'b1;
        req_ctrl[i*4 +: 4] = op;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_sub[i]        = s;
        req_sign[i]       = g;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((m_busy || req_valid != 0 || outstanding != 0) && n < 80);
        if (n >= 80) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=busy required=idle cyc=%0d", cyc);
        end
    endtask

    initial begin
        int n;
        int base;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // both requesters together: req0 first, then req1, pointer wraps
        post(0, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
        post(1, OP_OR, 32'hF0, 32'h0F, 1'b0, 1'b0);
        wait_idle();
        post(0, OP_XOR, 32'h3, 32'h5, 1'b0, 1'b0);
        post(1, OP_AND, 32'hFF, 32'h3C, 1'b0, 1'b0);
        wait_idle();
        chk("t2_count", 64'(served.size()), 64'd4);
        chk("t2_order", {16'(served[0]), 16'(served[1]), 16'(served[2]), 16'(served[3])},
            {16'd0, 16'd1, 16'd0, 16'd1});

        // single ADD
        post(0, OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0);
        wait_idle();
        chk("t1_res", 64'(last_res), 64'd12);
        chk("t1_zf", 64'(last_fl[0]), 64'd0);

        // branch compares from requester 1
        post(1, OP_BEQ, 32'h10, 32'h10, 1'b1, 1'b0);
        wait_idle();
        chk("t3_beq", {last_fl[3], last_fl[0]}, 64'b11);
        post(1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        wait_idle();
        chk("t3_blt", 64'(last_fl[3]), 64'd1);

        // response back-pressure with the other requester waiting
        rr_mode = 1;
        post(0, OP_ADD, 32'd100, 32'd30, 1'b1, 1'b0);
        n = 0;
        while (resp_valid == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_resp_seen", 64'(n < 20), 64'd1);
        post(1, OP_SLL, 32'd1, 32'd4, 1'b0, 1'b0);
        repeat (5) tick();
        rr_mode = 0;
        wait_idle();
        chk("t4_res", 64'(last_res), 64'd16);

        // ALU never answers: timeout response, then a normal op
        force_supp = 1'b1;
        post(0, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_idle();
        force_supp = 1'b0;
        chk("t5_err", {last_err, last_fl, last_res}, {1'b1, 4'h0, 32'h0});
        post(0, OP_ADD, 32'd3, 32'd4, 1'b0, 1'b0);
        wait_idle();
        chk("t5_next", {last_err, last_res}, {1'b0, 32'd7});

        // reset while waiting for the ALU: no response, then normal op
        base = nresp;
        post(0, OP_ADD, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_dropped", 64'(nresp), 64'(base));
        post(1, OP_XOR, 32'hF0, 32'h0F, 1'b0, 1'b0);
        wait_idle();
        chk("t6_after", {last_err, last_res}, {1'b0, 32'hFF});

        // random traffic with random back-pressure and timeouts
        rr_mode   = 2;
        rand_supp = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && !outstanding[i] && $urandom_range(0, 2) == 0)
                    post(i, ops[$urandom_range(0, 11)], $urandom, $urandom,
                         1'($urandom), 1'($urandom));
        end
        rand_supp = 1'b0;
        rr_mode   = 0;
        wait_idle();
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
